// File: rtl/reg_file_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_ctrl_pkg
// Purpose  : Shared types and constants for the register-file instruction
//            sequencer: FSM states, decode classes, register-file indices,
//            ALU operation codes and the 8085 register-code mapping.
// Revision : 1.0  initial release
// ============================================================================
package reg_file_ctrl_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_OPND   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // Instruction classes produced by the decoder.
  typedef enum logic [2:0] {
    CLS_NOP     = 3'd0,
    CLS_HLT     = 3'd1,
    CLS_MOVE    = 3'd2,  // MOV and MVI: write one file register
    CLS_ALU     = 3'd3,  // register, M and immediate ALU forms
    CLS_ILLEGAL = 3'd4
  } instr_class_t;

  // Register-file indices (op1_select / op2_select / reg_we bit positions).
  localparam logic [2:0] c_IDX_A   = 3'd0;
  localparam logic [2:0] c_IDX_B   = 3'd1;
  localparam logic [2:0] c_IDX_C   = 3'd2;
  localparam logic [2:0] c_IDX_D   = 3'd3;
  localparam logic [2:0] c_IDX_E   = 3'd4;
  localparam logic [2:0] c_IDX_H   = 3'd5;
  localparam logic [2:0] c_IDX_L   = 3'd6;
  localparam logic [2:0] c_IDX_MEM = 3'd7;

  // ALU operations, taken straight from opcode bits [5:3].
  localparam logic [2:0] c_ALU_ADD = 3'd0;
  localparam logic [2:0] c_ALU_ADC = 3'd1;
  localparam logic [2:0] c_ALU_SUB = 3'd2;
  localparam logic [2:0] c_ALU_SBB = 3'd3;
  localparam logic [2:0] c_ALU_ANA = 3'd4;
  localparam logic [2:0] c_ALU_XRA = 3'd5;
  localparam logic [2:0] c_ALU_ORA = 3'd6;
  localparam logic [2:0] c_ALU_CMP = 3'd7;

  // Special opcodes and 8085 register codes.
  localparam logic [7:0] c_OP_NOP = 8'h00;
  localparam logic [7:0] c_OP_HLT = 8'h76;
  localparam logic [2:0] c_CODE_M = 3'b110;
  localparam logic [2:0] c_CODE_A = 3'b111;

  // 8085 register code -> file index: A(111)->0, B..L(000..101)->1..6,
  // M(110)->7 (the mem_data operand path).
  function automatic logic [2:0] code_to_idx(input logic [2:0] code);
    if (code == c_CODE_A) begin
      return c_IDX_A;
    end else if (code == c_CODE_M) begin
      return c_IDX_MEM;
    end else begin
      return code + 3'd1;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_ctrl_decode
// Purpose  : Combinational classifier for the latched instruction byte.
// Ports    : i_ir          - instruction register
//            o_class       - instruction class
//            o_dst_idx     - destination file index (MOV/MVI)
//            o_src_idx     - source file index (7 = mem_data)
//            o_needs_opnd  - instruction fetches a second byte
//            o_use_hl      - that byte is addressed by H:L (M operand)
//            o_illegal     - opcode outside the supported subset
// Revision : 1.0  initial release
// ============================================================================
module reg_file_ctrl_decode
  import reg_file_ctrl_pkg::*;
(
  input  logic [7:0]   i_ir,
  output instr_class_t o_class,
  output logic [2:0]   o_dst_idx,
  output logic [2:0]   o_src_idx,
  output logic         o_needs_opnd,
  output logic         o_use_hl,
  output logic         o_illegal
);

  logic [2:0] w_dst_code;
  logic [2:0] w_src_code;

  assign w_dst_code = i_ir[5:3];
  assign w_src_code = i_ir[2:0];

  always_comb begin
    o_class      = CLS_ILLEGAL;
    // MVI and immediate ALU forms carry 110 in the source field, so the
    // mapping already points them at the mem_data path.
    o_dst_idx    = code_to_idx(w_dst_code);
    o_src_idx    = code_to_idx(w_src_code);
    o_needs_opnd = 1'b0;
    o_use_hl     = 1'b0;

    if (i_ir == c_OP_NOP) begin
      o_class = CLS_NOP;
    end else if (i_ir == c_OP_HLT) begin
      o_class = CLS_HLT;
    end else begin
      case (i_ir[7:6])
        2'b01: begin
          // MOV d,s; a memory destination is not supported.
          if (w_dst_code != c_CODE_M) begin
            o_class = CLS_MOVE;
            if (w_src_code == c_CODE_M) begin
              o_needs_opnd = 1'b1;
              o_use_hl     = 1'b1;
            end
          end
        end
        2'b00: begin
          // Only MVI r (00ddd110) is decoded in this quadrant.
          if (w_src_code == c_CODE_M && w_dst_code != c_CODE_M) begin
            o_class      = CLS_MOVE;
            o_needs_opnd = 1'b1;
          end
        end
        2'b10: begin
          o_class = CLS_ALU;
          if (w_src_code == c_CODE_M) begin
            o_needs_opnd = 1'b1;
            o_use_hl     = 1'b1;
          end
        end
        default: begin
          // Only the immediate ALU forms (11ooo110) are decoded here.
          if (w_src_code == c_CODE_M) begin
            o_class      = CLS_ALU;
            o_needs_opnd = 1'b1;
          end
        end
      endcase
    end

    o_illegal = (o_class == CLS_ILLEGAL);
  end

endmodule
`default_nettype wire

// File: rtl/reg_file_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_ctrl
// Purpose  : Instruction sequencer for the 8-bit register file. Fetches 8085
//            opcode/immediate bytes over a byte handshake, decodes MOV, MVI,
//            the eight ALU ops (register, M, immediate), NOP and HLT, and
//            drives the register-file selects/write enables and ALU controls.
// Ports    : clk, rst                    - clock, synchronous active-high reset
//            mem_data, mem_valid         - returned memory byte
//            mem_rd, mem_hl, pc_inc      - byte request, address source, PC step
//            resume                      - leave HALT
//            op1_select, op2_select      - register-file operand selects
//            reg_we, store_alu_a_reg     - register / accumulator write strobes
//            alu_op, flag_we             - ALU operation and flag update
//            halted, illegal_op, instr_done - status
// Revision : 1.0  initial release
// ============================================================================
module reg_file_ctrl
  import reg_file_ctrl_pkg::*;
#(
  parameter bit RESET_HALTED = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] mem_data,
  input  logic       mem_valid,
  output logic       mem_rd,
  output logic       mem_hl,
  output logic       pc_inc,
  input  logic       resume,
  output logic [2:0] op1_select,
  output logic [2:0] op2_select,
  output logic [6:0] reg_we,
  output logic       store_alu_a_reg,
  output logic [2:0] alu_op,
  output logic       flag_we,
  output logic       halted,
  output logic       illegal_op,
  output logic       instr_done
);

  state_t       r_state;
  logic [7:0]   r_ir;

  instr_class_t w_class;
  logic [2:0]   w_dst_idx;
  logic [2:0]   w_src_idx;
  logic         w_needs_opnd;
  logic         w_use_hl;
  logic         w_illegal;
  logic [6:0]   w_dst_onehot;
  logic         w_write;
  logic         w_in_body;

  reg_file_ctrl_decode u_decode (
    .i_ir         (r_ir),
    .o_class      (w_class),
    .o_dst_idx    (w_dst_idx),
    .o_src_idx    (w_src_idx),
    .o_needs_opnd (w_needs_opnd),
    .o_use_hl     (w_use_hl),
    .o_illegal    (w_illegal)
  );

  // One-hot destination enable; decode never yields a MOVE with dst 7.
  for (genvar gi = 0; gi < 7; gi++) begin : g_dst_onehot
    assign w_dst_onehot[gi] = (w_dst_idx == 3'(gi));
  end

  // --------------------------------------------------------------------------
  // Sequencer state and instruction register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RESET_HALTED ? ST_HALT : ST_FETCH;
      r_ir    <= 8'h00;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (mem_valid) begin
            r_ir    <= mem_data;
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          case (w_class)
            CLS_HLT:  r_state <= ST_HALT;
            CLS_MOVE,
            CLS_ALU:  r_state <= w_needs_opnd ? ST_OPND : ST_EXEC;
            default:  r_state <= ST_FETCH;  // NOP and illegal opcodes
          endcase
        end
        ST_OPND: begin
          if (mem_valid) begin
            r_state <= ST_FETCH;
          end
        end
        ST_EXEC: r_state <= ST_FETCH;
        ST_HALT: begin
          if (resume) begin
            r_state <= ST_FETCH;
          end
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output decode
  // The write in OPND must land in the cycle mem_valid arrives (mem_data
  // reaches reg_out1 combinationally), and reset must blank every output
  // immediately, so outputs are decoded from state plus the handshake rather
  // than registered.
  // --------------------------------------------------------------------------
  assign w_in_body = (r_state == ST_OPND) || (r_state == ST_EXEC);
  assign w_write   = (r_state == ST_EXEC) || ((r_state == ST_OPND) && mem_valid);

  always_comb begin
    mem_rd          = 1'b0;
    mem_hl          = 1'b0;
    pc_inc          = 1'b0;
    op1_select      = c_IDX_A;
    op2_select      = c_IDX_A;  // ALU second operand is always A
    reg_we          = 7'b0;
    store_alu_a_reg = 1'b0;
    alu_op          = c_ALU_ADD;
    flag_we         = 1'b0;
    halted          = 1'b0;
    illegal_op      = 1'b0;
    instr_done      = 1'b0;

    if (!rst) begin
      case (r_state)
        ST_FETCH: begin
          mem_rd = 1'b1;
          pc_inc = mem_valid;
        end
        ST_DECODE: begin
          instr_done = (w_class == CLS_NOP) || (w_class == CLS_HLT);
          illegal_op = w_illegal;
        end
        ST_OPND: begin
          mem_rd     = 1'b1;
          mem_hl     = w_use_hl;
          // The PC only advances for immediate bytes, not H:L reads.
          pc_inc     = mem_valid && !w_use_hl;
          op1_select = c_IDX_MEM;
          instr_done = mem_valid;
        end
        ST_EXEC: begin
          op1_select = w_src_idx;
          instr_done = 1'b1;
        end
        ST_HALT: begin
          halted = 1'b1;
        end
        default: ;
      endcase

      if (w_in_body && (w_class == CLS_ALU)) begin
        alu_op = r_ir[5:3];
      end

      if (w_write) begin
        if (w_class == CLS_MOVE) begin
          reg_we = w_dst_onehot;
        end else if (w_class == CLS_ALU) begin
          flag_we         = 1'b1;
          // CMP only updates flags; A keeps its value.
          store_alu_a_reg = (r_ir[5:3] != c_ALU_CMP);
        end
      end
    end
  end

endmodule
`default_nettype wire
